// File: rtl/mips_muldiv_ctrl.sv
// rtl/mips_muldiv_ctrl.sv - iterative MIPS multiply/divide sequencer owning HI/LO
module mips_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_en,
    input  logic             lo_en,
    input  logic             mf_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // Sequencer state
    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;           // negate product / quotient
    logic               rem_neg_q, rem_neg_d;   // remainder takes dividend sign
    logic               dz_q, dz_d;             // divide by zero
    logic [WIDTH-1:0]   b_q, b_d;               // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;           // {upper, lower}: {prod_hi, multiplier} or {rem, quo}

    // Architectural registers and status
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Operand conditioning at issue: op[0]=0 selects the signed variants
    logic               is_signed_in;
    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_abs;
    logic [WIDTH-1:0]   rt_abs;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_r;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    // Final sign fix-up
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_raw;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Absolute values of the issuing operands
    always_comb begin
        is_signed_in = ~op[0];
        rs_neg       = is_signed_in & rs_data[WIDTH-1];
        rt_neg       = is_signed_in & rt_data[WIDTH-1];
        rs_abs       = rs_neg ? (~rs_data + 1'b1) : rs_data;
        rt_abs       = rt_neg ? (~rt_data + 1'b1) : rt_data;
    end

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Remainder stays below the divisor, so the trial difference never reaches
        // bit WIDTH unless it borrowed; the top bit is therefore the "rem < divisor" flag.
        div_r    = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_r - {1'b0, b_q};
        div_ge   = ~div_diff[WIDTH];
        div_next = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                          : {div_r[WIDTH-1:0],    acc_q[WIDTH-2:0], 1'b0};
    end

    // Signed results from magnitude results
    always_comb begin
        prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo_raw  = acc_q[WIDTH-1:0];
        rem_raw  = acc_q[2*WIDTH-1:WIDTH];
        quo_fix  = neg_q ? (~quo_raw + 1'b1) : quo_raw;
        rem_fix  = rem_neg_q ? (~rem_raw + 1'b1) : rem_raw;
    end

    // Next-state logic for the IDLE/RUN/FIN sequencer and HI/LO
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        b_d       = b_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    neg_d     = rs_neg ^ rt_neg;
                    rem_neg_d = rs_neg;
                    dz_d      = (rt_data == {WIDTH{1'b0}});
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
                    if (op[1]) begin
                        b_d   = rt_abs;
                        acc_d = {{WIDTH{1'b0}}, rs_abs};
                    end else begin
                        b_d   = rs_abs;
                        acc_d = {{WIDTH{1'b0}}, rt_abs};
                    end
                end else begin
                    if (hi_en) hi_d = rs_data;
                    if (lo_en) lo_d = rs_data;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_FIN;
            end
            S_FIN: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = dz_q ? {WIDTH{1'b1}} : quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            b_q       <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Stall any HI/LO user or new issue while an operation is in flight
    always_comb begin
        stall = busy_q & (start | hi_en | lo_en | mf_req);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// tb/tb_mips_muldiv_ctrl.sv - table-driven bench for mips_muldiv_ctrl
module tb_mips_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_en;
    logic        lo_en;
    logic        mf_req;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        bit          mf;
        bit          extra;
        bit          hien;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    mips_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_en   (hi_en),
        .lo_en   (lo_en),
        .mf_req  (mf_req),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Inputs for the op already sit on the bus; E0 is the next rising edge.
    task automatic run_op(input int idx, input vec_t v, input bit chain, input vec_t nx);
        int busy_n;
        int stall_n;
        int stall_exp;
        int done_n;
        int hold_bad;
        busy_n = 0; stall_n = 0; stall_exp = 0; done_n = 0; hold_bad = 0;
        @(posedge clk);
        #1;
        start = 1'b0; hi_en = 1'b0; lo_en = 1'b0;
        for (int k = 0; k < 33; k++) begin
            @(negedge clk);
            mf_req = v.mf && (k >= 3);
            if (v.extra && k == 5) begin
                start = 1'b1; op = 2'b01; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
            end else begin
                start = 1'b0;
            end
            if (mf_req || start) stall_exp++;
            #1;
            if (busy) busy_n++;
            if (stall) stall_n++;
            if (done) done_n++;
            if (hi !== m_hi || lo !== m_lo) hold_bad++;
        end
        @(negedge clk);
        start = 1'b0;
        if (chain) begin
            start = 1'b1; op = nx.op; rs_data = nx.rs; rt_data = nx.rt; hi_en = nx.hien;
        end
        #1;
        check($sformatf("v%0d busy_cycles", idx), 32'(busy_n), 32'd33);
        check($sformatf("v%0d stall_cycles", idx), 32'(stall_n), 32'(stall_exp));
        check($sformatf("v%0d early_done", idx), 32'(done_n), 32'd0);
        check($sformatf("v%0d hilo_held", idx), 32'(hold_bad), 32'd0);
        check($sformatf("v%0d done", idx), 32'(done), 32'd1);
        check($sformatf("v%0d busy_end", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d stall_end", idx), 32'(stall), 32'd0);
        check($sformatf("v%0d hi", idx), hi, v.exp_hi);
        check($sformatf("v%0d lo", idx), lo, v.exp_lo);
        mf_req = 1'b0;
        m_hi = v.exp_hi;
        m_lo = v.exp_lo;
        if (!chain) begin
            @(negedge clk);
            #1;
            check($sformatf("v%0d done_pulse", idx), 32'(done), 32'd0);
        end
    endtask

    initial begin
        int cnt_bad;
        vec_t v67;

        vt[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        1'b1, 1'b0, 1'b0};
        vt[4]  = '{2'b11, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{2'b10, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b0, 1'b0, 1'b0};
        vt[9]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0};
        vt[10] = '{2'b01, 32'h8000_0000, 32'd2,        32'd1,         32'd0,         1'b0, 1'b0, 1'b0};
        vt[11] = '{2'b00, 32'd6,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 1'b0, 1'b0};
        v67    = '{2'b00, 32'd6,         32'd7,        32'd0,         32'd42,        1'b0, 1'b0, 1'b0};

        rst_b = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hi_en = 1'b0; lo_en = 1'b0; mf_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;

        // MTHI then MTLO in consecutive cycles
        @(negedge clk);
        hi_en = 1'b1; rs_data = 32'h1234_5678; mf_req = 1'b1;
        #1;
        check("idle stall", 32'(stall), 32'd0);
        @(negedge clk);
        hi_en = 1'b0; lo_en = 1'b1; rs_data = 32'h9ABC_DEF0; mf_req = 1'b0;
        #1;
        check("mthi hi", hi, 32'h1234_5678);
        check("mthi lo", lo, 32'd0);
        @(negedge clk);
        lo_en = 1'b0;
        #1;
        check("mtlo lo", lo, 32'h9ABC_DEF0);
        check("mtlo hi", hi, 32'h1234_5678);
        // Both writes in one cycle
        @(negedge clk);
        hi_en = 1'b1; lo_en = 1'b1; rs_data = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_en = 1'b0; lo_en = 1'b0;
        #1;
        check("both hi", hi, 32'hA5A5_A5A5);
        check("both lo", lo, 32'hA5A5_A5A5);
        m_hi = 32'hA5A5_A5A5;
        m_lo = 32'hA5A5_A5A5;

        // Table of operations, issued back-to-back on each done cycle
        @(negedge clk);
        start = 1'b1; op = vt[0].op; rs_data = vt[0].rs; rt_data = vt[0].rt; hi_en = vt[0].hien;
        for (int i = 0; i < NV; i++) begin
            run_op(i, vt[i], i < NV - 1, vt[(i + 1) % NV]);
        end

        // Reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs_data = 32'd1234; rt_data = 32'd5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (16) @(negedge clk);
        mf_req = 1'b1;
        rst_b = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst stall", 32'(stall), 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        check("midrst done", 32'(done), 32'd0);
        @(negedge clk);
        rst_b = 1'b1; mf_req = 1'b0;
        cnt_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done || busy || hi != 32'd0 || lo != 32'd0) cnt_bad++;
        end
        check("midrst quiet", 32'(cnt_bad), 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        start = 1'b1; op = v67.op; rs_data = v67.rs; rt_data = v67.rt;
        run_op(99, v67, 1'b0, v67);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
